// File: rtl/axi4_pkg.sv
// Shared AXI4-Lite constants and FSM state types for the slave memory.
package axi4_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int STRB_W     = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write path: idle/collecting AW+W, or holding a B response.
    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wst_e;

    // Read path: idle/accepting AR, or holding an R response.
    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rst_e;

endpackage

// File: rtl/axi4_slave_mem_array.sv
// DEPTH x 32 storage, one array per byte lane so each strobe bit gates its
// own lane. Asynchronous read; the parent registers the read data.
module axi4_slave_mem_array
    import axi4_pkg::*;
#(
    parameter int DEPTH = 256,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [AXI_DATA_W-1:0] wdata_i,
    input  logic [STRB_W-1:0]     wstrb_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [AXI_DATA_W-1:0] rdata_o
);

    generate
        for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
            logic [7:0] lane_q [DEPTH];

            // Byte-lane write, enabled by its strobe bit.
            always_ff @(posedge clk) begin
                if (we_i && wstrb_i[gi]) begin
                    lane_q[waddr_i] <= wdata_i[8*gi +: 8];
                end
            end

            assign rdata_o[8*gi +: 8] = lane_q[raddr_i];
        end
    endgenerate

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4-Lite slave backed by a word-addressed on-chip memory. Independent
// write (AW/W holding regs + B) and read (AR -> registered R) paths.
module axi4_slave_mem
    import axi4_pkg::*;
#(
    parameter int                    DEPTH     = 256,
    parameter logic [AXI_ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [AXI_ADDR_W-1:0] awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [AXI_DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0]     wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [AXI_ADDR_W-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [AXI_DATA_W-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready
);

    localparam int IDX_W = $clog2(DEPTH);

    // State registers
    wst_e                  wst_q, wst_d;
    rst_e                  rst_q, rst_d;
    logic                  out_en_q;
    logic                  aw_full_q, aw_full_d;
    logic [AXI_ADDR_W-1:0] aw_addr_q, aw_addr_d;
    logic                  w_full_q, w_full_d;
    logic [AXI_DATA_W-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0]     w_strb_q, w_strb_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [AXI_DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    // Address decode. BASE_ADDR is aligned to the window size, so any address
    // below BASE wraps to an offset >= DEPTH*4; the window test therefore
    // reduces to "offset bits above the word index are all zero".
    logic [AXI_ADDR_W-1:0] aw_off, ar_off;
    logic                  aw_in_range, ar_in_range;
    logic                  unused_addr_lsbs;

    assign aw_off      = aw_addr_q - BASE_ADDR;
    assign ar_off      = araddr - BASE_ADDR;
    assign aw_in_range = (aw_off[AXI_ADDR_W-1:IDX_W+2] == '0);
    assign ar_in_range = (ar_off[AXI_ADDR_W-1:IDX_W+2] == '0);
    assign unused_addr_lsbs = ^{aw_off[1:0], ar_off[1:0]};

    // Handshakes. out_en_q keeps every ready low while reset is applied and
    // for the reset edge itself.
    logic aw_hs, w_hs, ar_hs;
    assign awready = out_en_q && !aw_full_q && (wst_q == W_IDLE);
    assign wready  = out_en_q && !w_full_q  && (wst_q == W_IDLE);
    assign arready = out_en_q && (rst_q == R_IDLE);
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid  && wready;
    assign ar_hs   = arvalid && arready;

    assign bvalid = (wst_q == W_RESP);
    assign bresp  = bresp_q;
    assign rvalid = (rst_q == R_DATA);
    assign rdata  = rdata_q;
    assign rresp  = rresp_q;

    // Memory
    logic                  mem_we;
    logic [AXI_DATA_W-1:0] mem_rdata;

    axi4_slave_mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (aw_off[IDX_W+1:2]),
        .wdata_i (w_data_q),
        .wstrb_i (w_strb_q),
        .raddr_i (ar_off[IDX_W+1:2]),
        .rdata_o (mem_rdata)
    );

    // Next-state logic for both FSMs, holding regs and response regs.
    always_comb begin
        wst_d     = wst_q;
        rst_d     = rst_q;
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bresp_d   = bresp_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        mem_we    = 1'b0;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = awaddr;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = wdata;
            w_strb_d = wstrb;
        end

        case (wst_q)
            W_IDLE: begin
                // Commit once both halves are held; readies are low while
                // full so no new capture can coincide with this.
                if (aw_full_q && w_full_q) begin
                    mem_we    = aw_in_range;
                    bresp_d   = aw_in_range ? RESP_OKAY : RESP_SLVERR;
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                    wst_d     = W_RESP;
                end
            end
            W_RESP: begin
                if (bready) begin
                    wst_d = W_IDLE;
                end
            end
            default: wst_d = W_IDLE;
        endcase

        case (rst_q)
            R_IDLE: begin
                // Read data comes from the array before any same-edge write
                // lands, so a colliding read returns the old word.
                if (ar_hs) begin
                    rdata_d = ar_in_range ? mem_rdata : '0;
                    rresp_d = ar_in_range ? RESP_OKAY : RESP_SLVERR;
                    rst_d   = R_DATA;
                end
            end
            R_DATA: begin
                if (rready) begin
                    rst_d = R_IDLE;
                end
            end
            default: rst_d = R_IDLE;
        endcase
    end

    // State update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wst_q     <= W_IDLE;
            rst_q     <= R_IDLE;
            out_en_q  <= 1'b0;
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            wst_q     <= wst_d;
            rst_q     <= rst_d;
            out_en_q  <= 1'b1;
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bresp_q   <= bresp_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed bench for axi4_slave_mem with immediate-assertion checks.
module tb_axi4_slave_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axi4_slave_mem #(
        .DEPTH     (256),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // AW and W in the same cycle, then wait (bounded) for B and accept it.
    task automatic write_word(input string tag, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [1:0] exp_resp);
        int n;
        awaddr = a; awvalid = 1'b1;
        wdata  = d; wstrb   = s; wvalid = 1'b1;
        bready = 1'b1;
        check({tag, "_awready"}, {31'd0, awready}, 32'd1);
        check({tag, "_wready"},  {31'd0, wready},  32'd1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_bvalid"}, {31'd0, bvalid}, 32'd1);
        check({tag, "_bresp"},  {30'd0, bresp},  {30'd0, exp_resp});
        $display("write %s addr=%h data=%h strb=%h bresp=%0d", tag, a, d, s, bresp);
        tick();
    endtask

    // Single read, bounded wait for R, then accept it.
    task automatic read_word(input string tag, input logic [31:0] a,
                             input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int n;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        check({tag, "_arready"}, {31'd0, arready}, 32'd1);
        tick();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
        check({tag, "_rdata"},  rdata, exp_data);
        check({tag, "_rresp"},  {30'd0, rresp}, {30'd0, exp_resp});
        $display("read %s addr=%h rdata=%h rresp=%0d", tag, a, rdata, rresp);
        tick();
    endtask

    initial begin
        reset   = 1'b0;
        awaddr  = '0; awvalid = 1'b0;
        wdata   = '0; wstrb   = '0; wvalid = 1'b0;
        bready  = 1'b0;
        araddr  = '0; arvalid = 1'b0;
        rready  = 1'b0;

        // Reset state
        tick(); tick(); tick();
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_wready",  {31'd0, wready},  32'd0);
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_bvalid",  {31'd0, bvalid},  32'd0);
        check("rst_rvalid",  {31'd0, rvalid},  32'd0);
        check("rst_rdata",   rdata, 32'd0);
        reset = 1'b1;
        check("rel_awready_pre", {31'd0, awready}, 32'd0);
        tick();
        check("rel_awready", {31'd0, awready}, 32'd1);
        check("rel_arready", {31'd0, arready}, 32'd1);

        // 1: AW+W same cycle, bvalid exactly two cycles after the handshake
        awaddr = 32'h10; awvalid = 1'b1;
        wdata  = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
        bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("t1_bvalid_n1", {31'd0, bvalid}, 32'd0);
        tick();
        check("t1_bvalid_n2", {31'd0, bvalid}, 32'd1);
        check("t1_bresp",     {30'd0, bresp},  32'd0);
        $display("write t1 addr=00000010 data=deadbeef bresp=%0d", bresp);
        tick();
        check("t1_bvalid_done", {31'd0, bvalid}, 32'd0);
        check("t1_awready_back", {31'd0, awready}, 32'd1);
        read_word("t1_rd", 32'h10, 32'hDEAD_BEEF, 2'b00);

        // 2: W first, AW three cycles later, partial strobes
        write_word("t2_init", 32'h14, 32'hAAAA_AAAA, 4'hF, 2'b00);
        wdata = 32'h1122_3344; wstrb = 4'b0101; wvalid = 1'b1; bready = 1'b1;
        tick();
        wvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("t2_no_commit", {31'd0, bvalid}, 32'd0);
            check("t2_wready_full", {31'd0, wready}, 32'd0);
            tick();
        end
        awaddr = 32'h14; awvalid = 1'b1;
        check("t2_awready", {31'd0, awready}, 32'd1);
        tick();
        awvalid = 1'b0;
        check("t2_bvalid_n1", {31'd0, bvalid}, 32'd0);
        tick();
        check("t2_bvalid_n2", {31'd0, bvalid}, 32'd1);
        check("t2_bresp", {30'd0, bresp}, 32'd0);
        $display("write t2 addr=00000014 data=11223344 strb=5 bresp=%0d", bresp);
        tick();
        read_word("t2_rd", 32'h14, 32'hAA22_AA44, 2'b00);

        // 3: one past the end of the window -> SLVERR, aliasing word 0 untouched
        write_word("t3_w0", 32'h0, 32'h1234_5678, 4'hF, 2'b00);
        write_word("t3_oob", 32'h400, 32'h5555_5555, 4'hF, 2'b10);
        read_word("t3_oob_rd", 32'h400, 32'h0, 2'b10);
        read_word("t3_w0_rd", 32'h0, 32'h1234_5678, 2'b00);

        // 4: B back-pressure holds response and blocks new writes
        awaddr = 32'h18; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        tick();
        awaddr = 32'h1C; wdata = 32'h0BAD_CAFE;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t4_bvalid_hold", {31'd0, bvalid}, 32'd1);
            check("t4_bresp_hold",  {30'd0, bresp},  32'd0);
            check("t4_awready_low", {31'd0, awready}, 32'd0);
            check("t4_wready_low",  {31'd0, wready},  32'd0);
            tick();
        end
        bready = 1'b1;
        check("t4_bvalid_pre", {31'd0, bvalid}, 32'd1);
        tick();
        check("t4_bvalid_done", {31'd0, bvalid}, 32'd0);
        check("t4_awready_back", {31'd0, awready}, 32'd1);
        check("t4_wready_back",  {31'd0, wready},  32'd1);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        check("t4_b2_bvalid", {31'd0, bvalid}, 32'd1);
        check("t4_b2_bresp",  {30'd0, bresp},  32'd0);
        $display("write t4 second addr=0000001c bresp=%0d", bresp);
        tick();
        read_word("t4_rd18", 32'h18, 32'hCAFE_F00D, 2'b00);
        read_word("t4_rd1c", 32'h1C, 32'h0BAD_CAFE, 2'b00);

        // 5: read and write commit to the same word on the same edge
        write_word("t5_init", 32'h20, 32'h1, 4'hF, 2'b00);
        awaddr = 32'h20; wdata = 32'h2; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h20; arvalid = 1'b1; rready = 1'b1;
        check("t5_arready", {31'd0, arready}, 32'd1);
        tick();
        arvalid = 1'b0;
        check("t5_rvalid", {31'd0, rvalid}, 32'd1);
        check("t5_rdata_old", rdata, 32'h1);
        check("t5_bvalid", {31'd0, bvalid}, 32'd1);
        $display("read t5 collide addr=00000020 rdata=%h", rdata);
        tick();
        read_word("t5_rd_new", 32'h20, 32'h2, 2'b00);

        // 6: reset while an R response is stalled
        araddr = 32'h10; arvalid = 1'b1; rready = 1'b0;
        tick();
        arvalid = 1'b0;
        check("t6_rvalid", {31'd0, rvalid}, 32'd1);
        tick();
        check("t6_rvalid_hold", {31'd0, rvalid}, 32'd1);
        check("t6_rdata_hold", rdata, 32'hDEAD_BEEF);
        reset = 1'b0;
        tick();
        check("t6_rvalid_rst", {31'd0, rvalid}, 32'd0);
        check("t6_arready_rst", {31'd0, arready}, 32'd0);
        reset = 1'b1;
        tick();
        check("t6_arready_rel", {31'd0, arready}, 32'd1);
        rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t6_no_stale_r", {31'd0, rvalid}, 32'd0);
            tick();
        end
        $display("reset t6 rvalid=%0d arready=%0d", rvalid, arready);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
